mono_sample_frame_buffer: RTL and testbench
===========================================

MONO_SAMPLE_FRAME_BUFFER -- requirements
Module: mono_sample_frame_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, mono sample width in bits.
REQ-002 SHALL have parameter FRAME_LEN, default 256, samples per frame; power of two, at least 4.
REQ-003 SHALL have port AXIS_ACLK  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port AXIS_ARESET  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port mono_sample_valid  input  1  one sample per cycle when high; no upstream backpressure exists.
REQ-006 SHALL have port mono_sample  input  DATA_WIDTH  mono sample, qualified by mono_sample_valid.
REQ-007 SHALL have port M_AXIS_TVALID  output  1  output word valid.
REQ-008 SHALL have port M_AXIS_TDATA  output  DATA_WIDTH  output sample.
REQ-009 SHALL have port M_AXIS_TLAST  output  1  high on the last word of each frame.
REQ-010 SHALL have port M_AXIS_TREADY  input  1  downstream (FFT) ready.
REQ-011 SHALL have port dropped_frames  output  16  count of overrun events; saturating.

Function
REQ-012 SHALL hold two banks (ping-pong) of FRAME_LEN words each, and each bank SHALL be in state EMPTY, FILLING, FULL or STREAMING.
REQ-013 Writer: each valid sample SHALL be stored at wr_idx in the filling bank, then wr_idx SHALL increment.
REQ-014 When wr_idx wraps from FRAME_LEN-1 to 0, the bank SHALL become FULL, and the writer SHALL switch to the other bank only if that bank is EMPTY at the same edge.
REQ-015 If the other bank is not EMPTY, the writer SHALL enter DROP: samples discarded, dropped_frames incremented once, saturating at 0xFFFF.
REQ-016 In DROP, the first valid sample after a bank becomes EMPTY SHALL be written at index 0 of that bank, so frames are never partial.
REQ-017 Reader FSM states SHALL be IDLE, LOAD (one-cycle RAM read latency) and STREAM.
REQ-018 IDLE -> LOAD SHALL occur when any bank is FULL; with both banks FULL, the older bank SHALL be read first.
REQ-019 M_AXIS_TVALID SHALL first rise exactly 2 cycles after the edge that wrote the last sample of a frame, provided the reader is IDLE.
REQ-020 Words SHALL be output in write order, indices 0..FRAME_LEN-1, and TLAST SHALL be asserted only at index FRAME_LEN-1.
REQ-021 A transfer SHALL occur only when TVALID and TREADY are both high.
REQ-022 While TVALID is high and TREADY is low, TDATA and TLAST SHALL stay stable and TVALID SHALL not drop.
REQ-023 With TREADY held high, the output SHALL sustain one word per cycle with no bubbles within a frame.
REQ-024 On the TLAST transfer, the bank SHALL become EMPTY at that edge, and the reader SHALL go to LOAD if the other bank is FULL, else to IDLE.
REQ-025 If the writer needs a bank on the same edge that the reader frees it, the writer SHALL see the bank as EMPTY (no drop).
REQ-026 Simultaneous write and read of different banks SHALL be supported every cycle.

Reset
REQ-027 While AXIS_ARESET is high at an edge, both banks SHALL become EMPTY, wr_idx and rd_idx 0, writer filling bank 0, reader IDLE.
REQ-028 During reset, M_AXIS_TVALID, M_AXIS_TLAST and M_AXIS_TDATA SHALL be 0 and dropped_frames SHALL be 0.
REQ-029 Reset mid-frame or mid-stall SHALL abandon all buffered data, with no TLAST emitted for the abandoned data; RAM contents need not be cleared.

Structure
REQ-030 Shared package audio_viz_pkg SHALL hold DATA_WIDTH, FRAME_LEN defaults, bank-state and reader-state encodings.
REQ-031 SHALL instantiate one sub-module frame_buffer_ram: simple dual-port, 2*FRAME_LEN x DATA_WIDTH, 1 write port, 1 synchronous read port, address = {bank, index}.

Verification (bench uses FRAME_LEN=8)
REQ-032 Reset: assert AXIS_ARESET 3 cycles, with valid inputs driven -> TVALID=0, TLAST=0, TDATA=0, dropped_frames=0.
REQ-033 Single frame: samples 1..8 on consecutive cycles, TREADY=1 -> TVALID rises 2 cycles after sample 8, TDATA 1..8 back-to-back, TLAST with 8 only.
REQ-034 Backpressure: frame 0x10..0x17, TREADY pattern 1,0,0,1 repeating -> same order, TDATA/TLAST stable through every stall, exactly one TLAST.
REQ-035 Overrun: TREADY=0, samples 1..24 -> dropped_frames=1; then TREADY=1 -> output is 1..16 with two TLASTs; samples 17..24 never appear.
REQ-036 Sustained rate: 10 frames, one sample every 4 cycles (stereo-pair cadence), TREADY=1 -> 80 words in order, 10 TLASTs, dropped_frames=0.
REQ-037 Mid-operation reset: reset after 5 samples of frame 2 while frame 1 is stalled -> TVALID=0 next cycle; new samples 0x20..0x27 output intact.

Source files
------------

// File: rtl/audio_viz_pkg.sv
// Shared types and defaults for the audio visualiser datapath.
// Holds the bank/reader state encodings used by the frame buffer.
package audio_viz_pkg;

  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefFrameLen  = 256;

  typedef enum logic [1:0] {
    BankEmpty,
    BankFilling,
    BankFull,
    BankStreaming
  } bank_state_e;

  typedef enum logic [1:0] {
    RdIdle,
    RdLoad,
    RdStream
  } rd_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/frame_buffer_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// The read register clears on reset so the stream output starts at zero.
module frame_buffer_ram #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 512,
  parameter int unsigned AddrW     = 9
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic [AddrW-1:0]     waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic                 re_i,
  input  logic [AddrW-1:0]     raddr_i,
  output logic [DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [DataWidth-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem_q[raddr_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mono_sample_frame_buffer.sv
// Ping-pong frame buffer: collects mono samples into FRAME_LEN-word frames and
// streams whole frames out over AXI-Stream; overruns drop whole frames only.
module mono_sample_frame_buffer
  import audio_viz_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned FRAME_LEN  = DefFrameLen
) (
  input  logic                  AXIS_ACLK,
  input  logic                  AXIS_ARESET,
  input  logic                  mono_sample_valid,
  input  logic [DATA_WIDTH-1:0] mono_sample,
  output logic                  M_AXIS_TVALID,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TLAST,
  input  logic                  M_AXIS_TREADY,
  output logic [15:0]           dropped_frames
);

  localparam int unsigned IdxW  = $clog2(FRAME_LEN);
  localparam int unsigned AddrW = IdxW + 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(FRAME_LEN - 1);

  bank_state_e bank_q [2];
  bank_state_e bank_d [2];

  logic            wr_bank_q, wr_bank_d;
  logic [IdxW-1:0] wr_idx_q, wr_idx_d;
  logic            drop_q, drop_d;
  logic [15:0]     dropped_q, dropped_d;
  logic            last_full_q, last_full_d;

  rd_state_e       rd_state_q, rd_state_d;
  logic            rd_bank_q, rd_bank_d;
  logic [IdxW-1:0] rd_idx_q, rd_idx_d;
  logic            tvalid_q, tvalid_d;
  logic            tlast_q, tlast_d;

  logic                  ram_we, ram_re;
  logic [AddrW-1:0]      ram_waddr, ram_raddr;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  sel_bank, free_bank;

  always_comb begin
    bank_d      = bank_q;
    wr_bank_d   = wr_bank_q;
    wr_idx_d    = wr_idx_q;
    drop_d      = drop_q;
    dropped_d   = dropped_q;
    last_full_d = last_full_q;
    rd_state_d  = rd_state_q;
    rd_bank_d   = rd_bank_q;
    rd_idx_d    = rd_idx_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    ram_re      = 1'b0;
    ram_raddr   = {rd_bank_q, rd_idx_q};
    ram_we      = 1'b0;
    ram_waddr   = {wr_bank_q, wr_idx_q};
    sel_bank    = 1'b0;
    free_bank   = 1'b0;

    // Reader is resolved first so a bank freed this edge is already EMPTY for the writer.
    unique case (rd_state_q)
      RdIdle: begin
        if (bank_q[0] == BankFull || bank_q[1] == BankFull) begin
          if (bank_q[0] == BankFull && bank_q[1] == BankFull) begin
            sel_bank = ~last_full_q;
          end else begin
            sel_bank = (bank_q[1] == BankFull);
          end
          bank_d[sel_bank] = BankStreaming;
          rd_bank_d        = sel_bank;
          rd_idx_d         = '0;
          rd_state_d       = RdLoad;
        end
      end
      RdLoad: begin
        ram_re     = 1'b1;
        rd_idx_d   = rd_idx_q + IdxW'(1);
        tvalid_d   = 1'b1;
        tlast_d    = (rd_idx_q == LastIdx);
        rd_state_d = RdStream;
      end
      RdStream: begin
        if (M_AXIS_TREADY) begin
          if (tlast_q) begin
            bank_d[rd_bank_q] = BankEmpty;
            tvalid_d          = 1'b0;
            tlast_d           = 1'b0;
            rd_idx_d          = '0;
            if (bank_q[~rd_bank_q] == BankFull) begin
              bank_d[~rd_bank_q] = BankStreaming;
              rd_bank_d          = ~rd_bank_q;
              rd_state_d         = RdLoad;
            end else begin
              rd_state_d = RdIdle;
            end
          end else begin
            ram_re   = 1'b1;
            rd_idx_d = rd_idx_q + IdxW'(1);
            tlast_d  = (rd_idx_q == LastIdx);
          end
        end
      end
      default: rd_state_d = RdIdle;
    endcase

    if (mono_sample_valid) begin
      if (!drop_q) begin
        ram_we            = 1'b1;
        bank_d[wr_bank_q] = BankFilling;
        wr_idx_d          = wr_idx_q + IdxW'(1);
        if (wr_idx_q == LastIdx) begin
          bank_d[wr_bank_q] = BankFull;
          last_full_d       = wr_bank_q;
          if (bank_d[~wr_bank_q] == BankEmpty) begin
            bank_d[~wr_bank_q] = BankFilling;
            wr_bank_d          = ~wr_bank_q;
          end else begin
            drop_d    = 1'b1;
            dropped_d = sat_inc16(dropped_q);
          end
        end
      end else if (bank_d[0] == BankEmpty || bank_d[1] == BankEmpty) begin
        // Leave DROP by starting a fresh frame at index 0 of the freed bank.
        free_bank         = (bank_d[0] != BankEmpty);
        ram_we            = 1'b1;
        ram_waddr         = {free_bank, {IdxW{1'b0}}};
        bank_d[free_bank] = BankFilling;
        wr_bank_d         = free_bank;
        wr_idx_d          = IdxW'(1);
        drop_d            = 1'b0;
      end
    end
  end

  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      bank_q[0]   <= BankEmpty;
      bank_q[1]   <= BankEmpty;
      wr_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      drop_q      <= 1'b0;
      dropped_q   <= '0;
      last_full_q <= 1'b0;
      rd_state_q  <= RdIdle;
      rd_bank_q   <= 1'b0;
      rd_idx_q    <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
    end else begin
      bank_q      <= bank_d;
      wr_bank_q   <= wr_bank_d;
      wr_idx_q    <= wr_idx_d;
      drop_q      <= drop_d;
      dropped_q   <= dropped_d;
      last_full_q <= last_full_d;
      rd_state_q  <= rd_state_d;
      rd_bank_q   <= rd_bank_d;
      rd_idx_q    <= rd_idx_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
    end
  end

  frame_buffer_ram #(
    .DataWidth(DATA_WIDTH),
    .Depth    (2 * FRAME_LEN),
    .AddrW    (AddrW)
  ) u_ram (
    .clk_i  (AXIS_ACLK),
    .rst_i  (AXIS_ARESET),
    .we_i   (ram_we),
    .waddr_i(ram_waddr),
    .wdata_i(mono_sample),
    .re_i   (ram_re),
    .raddr_i(ram_raddr),
    .rdata_o(ram_rdata)
  );

  assign M_AXIS_TVALID  = tvalid_q;
  assign M_AXIS_TLAST   = tlast_q;
  assign M_AXIS_TDATA   = ram_rdata;
  assign dropped_frames = dropped_q;

endmodule

// File: tb/tb_mono_sample_frame_buffer.sv
// Bench for mono_sample_frame_buffer with FRAME_LEN=8: scenario table plus
// hand-written reset/latency/mid-stall sequences, scored against a queue.
module tb_mono_sample_frame_buffer;

  localparam int unsigned Dw = 32;
  localparam int unsigned Fl = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid;
  logic [Dw-1:0] sample;
  logic          tvalid, tlast, tready;
  logic [Dw-1:0] tdata;
  logic [15:0]   drops;

  always #5 clk = ~clk;

  mono_sample_frame_buffer #(
    .DATA_WIDTH(Dw),
    .FRAME_LEN (Fl)
  ) dut (
    .AXIS_ACLK        (clk),
    .AXIS_ARESET      (rst),
    .mono_sample_valid(valid),
    .mono_sample      (sample),
    .M_AXIS_TVALID    (tvalid),
    .M_AXIS_TDATA     (tdata),
    .M_AXIS_TLAST     (tlast),
    .M_AXIS_TREADY    (tready),
    .dropped_frames   (drops)
  );

  typedef struct packed {
    logic          last;
    logic [Dw-1:0] data;
  } exp_t;

  typedef struct {
    string       name;
    int unsigned n;
    logic [31:0] first;
    int unsigned gap;
    logic [3:0]  pat;
    bit          hold;
    int unsigned keep;
    int unsigned exp_words;
    int unsigned exp_lasts;
    logic [15:0] exp_drops;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        tbl[4];
  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  int unsigned n_words, n_lasts, cyc = 0;
  bit          check_en = 0, hold = 0, prev_stall = 0;
  logic [3:0]  pat = 4'hF;
  logic          prev_last;
  logic [Dw-1:0] prev_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (!check_en) begin
      prev_stall = 0;
      return;
    end
    if (prev_stall) begin
      check("stall_hold", {31'd0, tvalid, tlast, tdata}, {31'd0, 1'b1, prev_last, prev_data});
    end
    if (tvalid && tready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", {31'd0, tlast, tdata}, 64'hDEAD);
      end else begin
        e = exp_q.pop_front();
        check("word", {31'd0, tlast, tdata}, {31'd0, e.last, e.data});
      end
      n_words++;
      if (tlast) n_lasts++;
    end
    prev_stall = tvalid && !tready;
    prev_last  = tlast;
    prev_data  = tdata;
  endtask

  // One cycle: score outputs mid-cycle, take the edge, then update TREADY.
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    tready = hold ? 1'b0 : pat[cyc % 4];
  endtask

  task automatic do_reset();
    check_en = 0;
    rst   = 1'b1;
    valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    n_words  = 0;
    n_lasts  = 0;
    check_en = 1;
  endtask

  task automatic send(input logic [31:0] first, input int unsigned n, input int unsigned gap,
                      input int unsigned keep);
    for (int i = 0; i < int'(n); i++) begin
      valid  = 1'b1;
      sample = first + 32'(i);
      if (i < int'(keep)) exp_q.push_back({(i % Fl) == Fl - 1, sample});
      tick();
      valid = 1'b0;
      for (int g = 1; g < int'(gap); g++) tick();
    end
  endtask

  task automatic drain();
    int unsigned t = 0;
    while ((exp_q.size() != 0 || tvalid) && t < 1000) begin
      tick();
      t++;
    end
    check("drain_pending", 64'(exp_q.size()) | {63'd0, tvalid}, 64'd0);
    repeat (4) tick();
  endtask

  initial begin
    tbl[0] = '{"single",    8,  32'h01, 1, 4'hF,    0, 8,  8,  1,  16'd0};
    tbl[1] = '{"backpress", 8,  32'h10, 1, 4'b1001, 0, 8,  8,  1,  16'd0};
    tbl[2] = '{"overrun",   24, 32'h01, 1, 4'hF,    1, 16, 16, 2,  16'd1};
    tbl[3] = '{"sustained", 80, 32'h01, 4, 4'hF,    0, 80, 80, 10, 16'd0};

    rst = 1'b1; valid = 1'b0; sample = '0; tready = 1'b1;

    // Reset held 3 cycles with live samples and TREADY high.
    valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sample = $urandom;
      tick();
      check("rst_tvalid", {63'd0, tvalid}, 64'd0);
      check("rst_tlast",  {63'd0, tlast},  64'd0);
      check("rst_tdata",  64'(tdata),      64'd0);
      check("rst_drops",  64'(drops),      64'd0);
    end
    valid = 1'b0;

    // First-word latency: TVALID two edges after the last sample write.
    pat = 4'hF; hold = 0;
    do_reset();
    send(32'h01, Fl, 1, Fl);
    check("lat_e0", {63'd0, tvalid}, 64'd0);
    tick();
    check("lat_e1", {63'd0, tvalid}, 64'd0);
    tick();
    check("lat_e2", {31'd0, tvalid, tdata}, {31'd0, 1'b1, 32'h1});
    drain();
    check("lat_words", 64'(n_words), 64'(Fl));
    check("lat_lasts", 64'(n_lasts), 64'd1);

    for (int v = 0; v < 4; v++) begin
      pat  = tbl[v].pat;
      hold = tbl[v].hold;
      do_reset();
      send(tbl[v].first, tbl[v].n, tbl[v].gap, tbl[v].keep);
      hold = 0;
      drain();
      check({tbl[v].name, "_words"}, 64'(n_words), 64'(tbl[v].exp_words));
      check({tbl[v].name, "_lasts"}, 64'(n_lasts), 64'(tbl[v].exp_lasts));
      check({tbl[v].name, "_drops"}, 64'(drops),   64'(tbl[v].exp_drops));
    end

    // Reset while frame 1 is stalled and frame 2 is part-written.
    pat = 4'hF; hold = 1;
    do_reset();
    check_en = 0;
    send(32'h01, Fl + 5, 1, 0);
    check("mid_stalled", {63'd0, tvalid}, 64'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_tvalid", {63'd0, tvalid}, 64'd0);
    check("mid_rst_tlast",  {63'd0, tlast},  64'd0);
    rst = 1'b0;
    hold = 0;
    exp_q.delete();
    n_words = 0; n_lasts = 0;
    check_en = 1;
    send(32'h20, Fl, 1, Fl);
    drain();
    check("mid_words", 64'(n_words), 64'(Fl));
    check("mid_lasts", 64'(n_lasts), 64'd1);
    check("mid_drops", 64'(drops),   64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
